// File: rtl/multicore_ctrl_pkg.sv
// Shared TL-UL types, register offsets and helpers for the multicore controller.
package multicore_ctrl_pkg;

  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  localparam logic [11:0] OffRun      = 12'h000;
  localparam logic [11:0] OffDoorbell = 12'h004;
  localparam logic [11:0] OffDbSet    = 12'h008;
  localparam logic [11:0] OffDbClr    = 12'h00C;
  localparam logic [11:0] OffDone     = 12'h010;
  localparam logic [11:0] OffDoneIe   = 12'h014;
  localparam logic [3:0]  BootPage    = 4'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  typedef enum logic [2:0] {
    SelRun, SelDoorbell, SelDbSet, SelDbClr, SelDone, SelDoneIe, SelBoot, SelNone
  } reg_sel_e;

  function automatic int hold_cnt_width(input int hold_cycles);
    return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/multicore_core_seq.sv
// Per-core reset hold sequencer and done-edge detector.
module multicore_core_seq
  import multicore_ctrl_pkg::*;
#(
  parameter int ResetHoldCycles = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic core_done_i,
  output logic core_rst_no,
  output logic done_set_o
);

  localparam int CntW = hold_cnt_width(ResetHoldCycles);

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic            run_q, rst_n_q, done_prev_q;

  // Only a fresh RUN rise loads the counter; a rewrite of 1 leaves it running down.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!run_i) begin
      hold_cnt_d = '0;
    end else if (!run_q) begin
      hold_cnt_d = CntW'(ResetHoldCycles);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= 1'b0;
      hold_cnt_q  <= '0;
      rst_n_q     <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      run_q       <= run_i;
      hold_cnt_q  <= hold_cnt_d;
      rst_n_q     <= run_i && run_q && (hold_cnt_d == '0);
      done_prev_q <= rst_n_q && core_done_i;
    end
  end

  assign core_rst_no = rst_n_q;
  assign done_set_o  = rst_n_q && core_done_i && !done_prev_q;

endmodule

// File: rtl/multicore_ctrl.sv
// TL-UL register slice controlling boot address, reset, doorbell and done of worker cores.
module multicore_ctrl
  import multicore_ctrl_pkg::*;
#(
  parameter int          NumCores        = 2,
  parameter int          ResetHoldCycles = 8,
  parameter logic [31:0] BootAddrRst     = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  tl_h2d_t                   tl_i,
  output tl_d2h_t                   tl_o,
  output logic [NumCores-1:0]       core_rst_no,
  output logic [NumCores-1:0][31:0] boot_addr_o,
  output logic [NumCores-1:0]       core_irq_o,
  input  logic [NumCores-1:0]       core_done_i,
  output logic                      mgmt_irq_o
);

  logic [NumCores-1:0]       run_q, doorbell_q, done_q, done_ie_q, done_set, done_w1c, wdata_cores;
  logic [NumCores-1:0][31:0] boot_addr_q;
  logic                      mgmt_irq_q;
  logic                      d_valid_q, d_error_q;
  logic [2:0]                d_opcode_q;
  logic [1:0]                d_size_q;
  logic [7:0]                d_source_q;
  logic [31:0]               d_data_q, rdata, boot_rdata;
  logic [11:0]               offset;
  logic [5:0]                boot_idx;
  reg_sel_e                  sel;
  logic                      is_get, is_put, boot_busy, req_err, a_ready, a_accept, wr_en;
  logic                      unused_tl;

  assign offset      = tl_i.a_address[11:0];
  assign boot_idx    = offset[7:2];
  assign wdata_cores = tl_i.a_data[NumCores-1:0];
  assign unused_tl   = ^{tl_i.a_param, tl_i.a_address[31:12]};

  always_comb begin
    sel = SelNone;
    case (offset)
      OffRun:      sel = SelRun;
      OffDoorbell: sel = SelDoorbell;
      OffDbSet:    sel = SelDbSet;
      OffDbClr:    sel = SelDbClr;
      OffDone:     sel = SelDone;
      OffDoneIe:   sel = SelDoneIe;
      default: begin
        if (offset[11:8] == BootPage && offset[1:0] == 2'b00 && 32'(boot_idx) < 32'(NumCores)) begin
          sel = SelBoot;
        end
      end
    endcase
  end

  always_comb begin
    boot_busy  = 1'b0;
    boot_rdata = '0;
    for (int i = 0; i < NumCores; i++) begin
      if (boot_idx == 6'(i)) begin
        boot_busy  = run_q[i];
        boot_rdata = boot_addr_q[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SelRun:      rdata = 32'(run_q);
      SelDoorbell: rdata = 32'(doorbell_q);
      SelDone:     rdata = 32'(done_q);
      SelDoneIe:   rdata = 32'(done_ie_q);
      SelBoot:     rdata = boot_rdata;
      default:     rdata = '0;
    endcase
  end

  // A running core's boot address is frozen so it can't change under the core.
  assign is_get  = tl_i.a_opcode == OpGet;
  assign is_put  = (tl_i.a_opcode == OpPutFull) || (tl_i.a_opcode == OpPutPartial);
  assign req_err = (sel == SelNone) || (tl_i.a_size != 2'd2) || !(is_get || is_put)
                || (is_put && tl_i.a_mask != 4'hF) || (is_put && sel == SelBoot && boot_busy);

  assign a_ready  = !d_valid_q || tl_i.d_ready;
  assign a_accept = tl_i.a_valid && a_ready;
  assign wr_en    = a_accept && is_put && !req_err;
  assign done_w1c = (wr_en && sel == SelDone) ? wdata_cores : '0;

  // A done edge in the same cycle as a W1C wins, so no completion is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q       <= '0;
      doorbell_q  <= '0;
      done_q      <= '0;
      done_ie_q   <= '0;
      mgmt_irq_q  <= 1'b0;
      boot_addr_q <= {NumCores{BootAddrRst}};
    end else begin
      done_q     <= (done_q & ~done_w1c) | done_set;
      mgmt_irq_q <= |(done_q & done_ie_q);
      if (wr_en) begin
        case (sel)
          SelRun:      run_q      <= wdata_cores;
          SelDoorbell: doorbell_q <= wdata_cores;
          SelDbSet:    doorbell_q <= doorbell_q | wdata_cores;
          SelDbClr:    doorbell_q <= doorbell_q & ~wdata_cores;
          SelDoneIe:   done_ie_q  <= wdata_cores;
          SelBoot: begin
            for (int i = 0; i < NumCores; i++) begin
              if (boot_idx == 6'(i)) boot_addr_q[i] <= tl_i.a_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid_q  <= 1'b0;
      d_error_q  <= 1'b0;
      d_opcode_q <= OpAccessAck;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
    end else if (a_accept) begin
      d_valid_q  <= 1'b1;
      d_error_q  <= req_err;
      d_opcode_q <= is_get ? OpAccessAckData : OpAccessAck;
      d_size_q   <= tl_i.a_size;
      d_source_q <= tl_i.a_source;
      d_data_q   <= (is_get && !req_err) ? rdata : '0;
    end else if (tl_i.d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  for (genvar i = 0; i < NumCores; i++) begin : g_core
    multicore_core_seq #(.ResetHoldCycles(ResetHoldCycles)) u_seq (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .run_i       (run_q[i]),
      .core_done_i (core_done_i[i]),
      .core_rst_no (core_rst_no[i]),
      .done_set_o  (done_set[i])
    );
  end

  assign tl_o = '{d_valid: d_valid_q, d_opcode: d_opcode_q, d_param: 3'b0, d_size: d_size_q,
                  d_source: d_source_q, d_sink: 1'b0, d_data: d_data_q, d_error: d_error_q,
                  a_ready: a_ready};

  assign boot_addr_o = boot_addr_q;
  assign core_irq_o  = doorbell_q;
  assign mgmt_irq_o  = mgmt_irq_q;

endmodule

// File: tb/tb_multicore_ctrl.sv
// Randomized and directed bench for multicore_ctrl against a cycle-level register model.
module tb_multicore_ctrl;
  import multicore_ctrl_pkg::*;

  localparam int          NCores   = 2;
  localparam int          Hold     = 8;
  localparam logic [31:0] BootRst  = 32'h0000_1000;
  localparam logic [15:0] CoreMask = 16'((1 << NCores) - 1);

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  tl_h2d_t                 tl_i;
  tl_d2h_t                 tl_o;
  logic [NCores-1:0]       core_rst_no, core_irq_o, core_done_i;
  logic [NCores-1:0][31:0] boot_addr_o;
  logic                    mgmt_irq_o;

  int vecs = 0, fails = 0, cyc = 0, src_ctr = 0;
  bit pend = 0;

  logic [15:0] run_m, db_m, done_m, ie_m, rst_m, prev_m;
  logic [31:0] boot_m [NCores];
  int          start_m [NCores];
  logic        irq_m, dv_m, de_m;
  logic [31:0] dd_m;
  logic [2:0]  dop_m;
  logic [7:0]  dsrc_m;
  logic [1:0]  dsz_m;

  logic [31:0] addrs [12] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014,
                              32'h100, 32'h104, 32'h108, 32'h200, 32'h012, 32'h0FC};
  logic [2:0]  ops [7] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd0, 3'd2, 3'd5};

  multicore_ctrl #(.NumCores(NCores), .ResetHoldCycles(Hold), .BootAddrRst(BootRst)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tl_i        (tl_i),
    .tl_o        (tl_o),
    .core_rst_no (core_rst_no),
    .boot_addr_o (boot_addr_o),
    .core_irq_o  (core_irq_o),
    .core_done_i (core_done_i),
    .mgmt_irq_o  (mgmt_irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecs++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    run_m = '0; db_m = '0; done_m = '0; ie_m = '0; rst_m = '0; prev_m = '0;
    irq_m = 0; dv_m = 0; de_m = 0; dd_m = '0; dop_m = '0; dsrc_m = '0; dsz_m = '0;
    cyc = 0;
    for (int i = 0; i < NCores; i++) begin
      boot_m[i] = BootRst;
      start_m[i] = 0;
    end
  endtask

  function automatic int decodeOffset(input logic [31:0] addr);
    logic [11:0] off;
    off = addr[11:0];
    case (off)
      12'h000: return 0;
      12'h004: return 1;
      12'h008: return 2;
      12'h00C: return 3;
      12'h010: return 4;
      12'h014: return 5;
      default: ;
    endcase
    for (int i = 0; i < NCores; i++) if (off == 12'(256 + 4 * i)) return 100 + i;
    return -1;
  endfunction

  // Advance the register model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    logic [15:0] new_rst, new_prev, set_v, w1c, wd;
    logic [31:0] rd;
    logic        is_get, is_put, err, acc, new_irq;
    int          kind;
    new_rst = '0; new_prev = '0; set_v = '0; w1c = '0;
    for (int i = 0; i < NCores; i++) begin
      new_rst[i]  = run_m[i] && (cyc >= start_m[i] + Hold + 1);
      set_v[i]    = rst_m[i] && core_done_i[i] && !prev_m[i];
      new_prev[i] = rst_m[i] && core_done_i[i];
    end
    new_irq = |(done_m & ie_m);
    acc = tl_i.a_valid && (!dv_m || tl_i.d_ready);
    if (acc) begin
      kind   = decodeOffset(tl_i.a_address);
      is_get = tl_i.a_opcode == 3'd4;
      is_put = tl_i.a_opcode == 3'd0 || tl_i.a_opcode == 3'd1;
      wd     = tl_i.a_data[15:0] & CoreMask;
      err = (kind < 0) || (tl_i.a_size != 2'd2) || !(is_get || is_put) ||
            (is_put && tl_i.a_mask != 4'hF) || (is_put && kind >= 100 && run_m[kind - 100]);
      case (kind)
        0: rd = {16'h0, run_m};
        1: rd = {16'h0, db_m};
        4: rd = {16'h0, done_m};
        5: rd = {16'h0, ie_m};
        default: rd = (kind >= 100) ? boot_m[kind - 100] : 32'h0;
      endcase
      if (is_put && !err) begin
        case (kind)
          0: begin
            for (int i = 0; i < NCores; i++) if (wd[i] && !run_m[i]) start_m[i] = cyc;
            run_m = wd;
          end
          1: db_m = wd;
          2: db_m = db_m | wd;
          3: db_m = db_m & ~wd;
          4: w1c = wd;
          5: ie_m = wd;
          default: if (kind >= 100) boot_m[kind - 100] = tl_i.a_data;
        endcase
      end
      dv_m = 1; de_m = err; dd_m = (is_get && !err) ? rd : 32'h0;
      dop_m = is_get ? 3'd1 : 3'd0; dsrc_m = tl_i.a_source; dsz_m = tl_i.a_size;
    end else if (tl_i.d_ready) begin
      dv_m = 0;
    end
    done_m = (done_m & ~w1c) | set_v;
    rst_m = new_rst; prev_m = new_prev; irq_m = new_irq;
  endtask

  task automatic checkAll();
    checkOutput("core_rst_no", 32'(core_rst_no), 32'(rst_m & CoreMask));
    checkOutput("core_irq_o", 32'(core_irq_o), 32'(db_m & CoreMask));
    checkOutput("mgmt_irq_o", 32'(mgmt_irq_o), 32'(irq_m));
    for (int i = 0; i < NCores; i++) checkOutput($sformatf("boot_addr_o[%0d]", i), boot_addr_o[i], boot_m[i]);
    checkOutput("a_ready", 32'(tl_o.a_ready), 32'(!dv_m || tl_i.d_ready));
    checkOutput("d_valid", 32'(tl_o.d_valid), 32'(dv_m));
    if (dv_m) begin
      checkOutput("d_data", tl_o.d_data, dd_m);
      checkOutput("d_error", 32'(tl_o.d_error), 32'(de_m));
      checkOutput("d_opcode", 32'(tl_o.d_opcode), 32'(dop_m));
      checkOutput("d_source", 32'(tl_o.d_source), 32'(dsrc_m));
      checkOutput("d_size", 32'(tl_o.d_size), 32'(dsz_m));
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    cyc++;
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic doTxn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata, output logic err);
    bit acc;
    acc = 0;
    tl_i.a_valid = 1; tl_i.a_opcode = op; tl_i.a_address = addr; tl_i.a_data = data;
    tl_i.a_mask = 4'hF; tl_i.a_size = 2'd2; tl_i.a_source = 8'(src_ctr); src_ctr++;
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = !dv_m || tl_i.d_ready;
      tick();
    end
    checkOutput("txn_accept", 32'(acc), 32'd1);
    tl_i.a_valid = 0;
    rdata = tl_o.d_data;
    err = tl_o.d_error;
  endtask

  task automatic applyStimulus();
    logic [31:0] r;
    bit acc;
    r = $urandom;
    if (!pend && $urandom_range(0, 2) != 0) begin
      tl_i.a_valid   = 1;
      tl_i.a_opcode  = ops[$urandom_range(0, 6)];
      tl_i.a_address = addrs[$urandom_range(0, 11)];
      tl_i.a_data    = $urandom;
      tl_i.a_mask    = ($urandom_range(0, 4) == 0) ? r[3:0] : 4'hF;
      tl_i.a_size    = ($urandom_range(0, 5) == 0) ? r[5:4] : 2'd2;
      tl_i.a_source  = r[15:8];
      pend = 1;
    end
    tl_i.d_ready = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 4) == 0) core_done_i = r[NCores+19:20];
    acc = pend && (!dv_m || tl_i.d_ready);
    tick();
    if (acc) begin
      pend = 0;
      tl_i.a_valid = 0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cnt;
    tl_i = '0;
    tl_i.d_ready = 1;
    core_done_i = '0;
    resetModel();
    repeat (3) @(negedge clk_i);
    checkOutput("rst_core_rst_no", 32'(core_rst_no), 32'd0);
    checkOutput("rst_boot_addr0", boot_addr_o[0], BootRst);
    checkOutput("rst_boot_addr1", boot_addr_o[1], BootRst);
    checkOutput("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    checkOutput("rst_mgmt_irq", 32'(mgmt_irq_o), 32'd0);
    checkOutput("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1;

    doTxn(OpPutFull, 32'h104, 32'h0010_0000, rd, er);
    checkOutput("boot1_write", boot_addr_o[1], 32'h0010_0000);
    doTxn(OpPutFull, 32'h000, 32'h2, rd, er);
    cnt = 0;
    while (core_rst_no[1] !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    checkOutput("rst_release_latency", 32'(cnt), 32'(Hold + 1));
    checkOutput("core0_held", 32'(core_rst_no[0]), 32'd0);

    doTxn(OpPutFull, 32'h104, 32'hDEAD_BEEF, rd, er);
    checkOutput("boot_busy_err", 32'(er), 32'd1);
    checkOutput("boot_busy_keep", boot_addr_o[1], 32'h0010_0000);
    doTxn(OpGet, 32'h200, 32'h0, rd, er);
    checkOutput("unmapped_err", 32'(er), 32'd1);
    checkOutput("unmapped_rdata", rd, 32'h0);

    doTxn(OpPutFull, 32'h008, 32'h3, rd, er);
    checkOutput("db_set_irq", 32'(core_irq_o), 32'h3);
    doTxn(OpPutFull, 32'h00C, 32'h1, rd, er);
    checkOutput("db_clr_irq", 32'(core_irq_o), 32'h2);
    doTxn(OpGet, 32'h004, 32'h0, rd, er);
    checkOutput("db_read", rd, 32'h2);

    doTxn(OpPutFull, 32'h000, 32'h3, rd, er);
    repeat (Hold + 2) tick();
    checkOutput("both_running", 32'(core_rst_no), 32'h3);
    doTxn(OpPutFull, 32'h014, 32'h1, rd, er);
    core_done_i[0] = 1;
    tick();
    tick();
    checkOutput("mgmt_irq_set", 32'(mgmt_irq_o), 32'd1);
    doTxn(OpGet, 32'h010, 32'h0, rd, er);
    checkOutput("done_read", rd, 32'h1);
    core_done_i[0] = 0;
    tick();
    core_done_i[0] = 1;
    doTxn(OpPutFull, 32'h010, 32'h1, rd, er);
    doTxn(OpGet, 32'h010, 32'h0, rd, er);
    checkOutput("done_set_wins", rd, 32'h1);
    doTxn(OpPutFull, 32'h010, 32'h1, rd, er);
    doTxn(OpGet, 32'h010, 32'h0, rd, er);
    checkOutput("done_w1c", rd, 32'h0);

    tick();
    tl_i.d_ready = 0;
    doTxn(OpGet, 32'h104, 32'h0, rd, er);
    checkOutput("stall_rdata", rd, 32'h0010_0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("stall_a_ready", 32'(tl_o.a_ready), 32'd0);
      checkOutput("stall_d_valid", 32'(tl_o.d_valid), 32'd1);
      checkOutput("stall_d_data", tl_o.d_data, 32'h0010_0000);
    end
    tl_i.d_ready = 1;
    tick();
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tl_i.a_valid = 1; tl_i.a_opcode = OpPutFull; tl_i.a_mask = 4'hF; tl_i.a_size = 2'd2;
      tl_i.a_address = (k % 2 == 0) ? 32'h014 : 32'h004;
      tl_i.a_data = 32'(k); tl_i.a_source = 8'(k);
      tick();
      if (tl_o.d_valid === 1'b1) cnt++;
    end
    tl_i.a_valid = 0;
    checkOutput("b2b_responses", 32'(cnt), 32'd4);

    for (int c = 0; c < 400; c++) applyStimulus();

    tl_i.a_valid = 0;
    pend = 0;
    tl_i.d_ready = 1;
    tick();
    tl_i.d_ready = 0;
    doTxn(OpGet, 32'h000, 32'h0, rd, er);
    rst_ni = 0;
    #1;
    checkOutput("midrst_d_valid", 32'(tl_o.d_valid), 32'd0);
    checkOutput("midrst_core_rst_no", 32'(core_rst_no), 32'd0);
    checkOutput("midrst_boot_addr1", boot_addr_o[1], BootRst);
    checkOutput("midrst_mgmt_irq", 32'(mgmt_irq_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
